// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS sequencer: state codes, opcodes,
// datapath mux selects and the control-word payload.
package mips_ctrl_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned ALUOP_W  = 3;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_I_EXEC   = 4'd11,
    S_I_WB     = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    CLS_MEM,
    CLS_RTYPE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_IMM,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b100;

  localparam logic [SEL_W-1:0] SRCB_REG     = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_SEXT    = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_SEXT_SH = 2'b11;

  localparam logic [SEL_W-1:0] PCS_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCS_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCS_JUMP   = 2'b10;

  // One control word per state, fanned out to the datapath.
  typedef struct packed {
    logic               pc_write;
    logic               pc_write_cond;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               alu_src_a;
    logic [SEL_W-1:0]   alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic [SEL_W-1:0]   pc_source;
    logic               unsign;
  } ctrl_t;

endpackage

// File: rtl/mcc_opclass.sv
// Combinational opcode classifier: instruction class plus the ALU op and
// immediate extension mode used by the I-type states.
import mips_ctrl_pkg::*;

module mcc_opclass (
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_t           op_class_c,
  output logic [ALUOP_W-1:0]  imm_alu_op_c,
  output logic                imm_unsign_c
);

  always_comb begin
    op_class_c   = CLS_ILLEGAL;
    imm_alu_op_c = ALU_ADD;
    imm_unsign_c = 1'b0;
    case (opcode)
      OP_LW, OP_SW: op_class_c = CLS_MEM;
      OP_RTYPE:     op_class_c = CLS_RTYPE;
      OP_BEQ:       op_class_c = CLS_BRANCH;
      OP_J:         op_class_c = CLS_JUMP;
      OP_ADDI:      op_class_c = CLS_IMM;
      OP_ANDI: begin
        op_class_c   = CLS_IMM;
        imm_alu_op_c = ALU_AND;
        imm_unsign_c = 1'b1;
      end
      OP_ORI: begin
        op_class_c   = CLS_IMM;
        imm_alu_op_c = ALU_OR;
        imm_unsign_c = 1'b1;
      end
      default: op_class_c = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the multicycle MIPS datapath with a retired-instruction
// counter. Define MCC_STALL_EN to add the mem_ready handshake on RAM states.
import mips_ctrl_pkg::*;

module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
`ifdef MCC_STALL_EN
  input  logic                mem_ready,
`endif
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [SEL_W-1:0]    alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [SEL_W-1:0]    pc_source,
  output logic                unsign,
  output logic [STATE_W-1:0]  state,
  output logic                illegal,
  output logic [CNT_W-1:0]    instr_count
);

  state_t             cur_state;
  state_t             next_state;
  ctrl_t              ctrl;
  op_class_t          op_class;
  logic [ALUOP_W-1:0] imm_alu_op;
  logic               imm_unsign;
  logic               mem_ok;
  logic               retire_c;

  // The branch decision (zero & pc_write_cond) is formed in the datapath.
  logic unused_zero;
  assign unused_zero = zero;

`ifdef MCC_STALL_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  mcc_opclass u_opclass (
    .opcode       (opcode),
    .op_class_c   (op_class),
    .imm_alu_op_c (imm_alu_op),
    .imm_unsign_c (imm_unsign)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= S_RESET;
    else       cur_state <= next_state;
  end

  // Next-state and Moore control decode.
  always_comb begin
    next_state = cur_state;
    ctrl       = '0;
    illegal    = 1'b0;
    case (cur_state)
      S_RESET: next_state = S_FETCH;
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCS_ALU;
        ctrl.pc_write  = mem_ok;
        if (mem_ok) next_state = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_SEXT_SH;
        ctrl.alu_op    = ALU_ADD;
        case (op_class)
          CLS_MEM:    next_state = S_MEM_ADDR;
          CLS_RTYPE:  next_state = S_R_EXEC;
          CLS_BRANCH: next_state = S_BRANCH;
          CLS_JUMP:   next_state = S_JUMP;
          CLS_IMM:    next_state = S_I_EXEC;
          default: begin
            next_state = S_FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_SEXT;
        ctrl.alu_op    = ALU_ADD;
        next_state     = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (mem_ok) next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        next_state      = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (mem_ok) next_state = S_FETCH;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
        next_state     = S_R_WB;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        next_state     = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_ALUOUT;
        next_state         = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
        next_state     = S_FETCH;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_SEXT;
        ctrl.alu_op    = imm_alu_op;
        ctrl.unsign    = imm_unsign;
        next_state     = S_I_WB;
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = imm_alu_op;
        ctrl.unsign    = imm_unsign;
        next_state     = S_FETCH;
      end
      default: next_state = S_RESET;
    endcase
  end

  // An instruction retires when its final state hands back to FETCH.
  always_comb begin
    retire_c = 1'b0;
    if (next_state == S_FETCH) begin
      retire_c = cur_state inside {S_MEM_WB, S_MEM_WR, S_R_WB,
                                   S_BRANCH, S_JUMP, S_I_WB};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         instr_count <= '0;
    else if (retire_c) instr_count <= instr_count + CNT_W'(1);
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign unsign        = ctrl.unsign;
  assign state         = cur_state;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencer for the MIPS datapath. It replaces the single-cycle `control` decode with a Moore state machine. Each instruction is broken into fetch, decode, execute, memory and writeback steps, which lets one ALU and one shared RAM be reused across cycles. It sits between the instruction register and every datapath mux, register enable and memory strobe, and also counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; forces RESET state and clears the counter.
- opcode  in  6  instruction[31:26] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  RAM done strobe; exists only with MCC_STALL_EN.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load when zero=1 (beq).
- iord  out  1  RAM address mux: 0=PC, 1=ALUOut.
- mem_read / mem_write  out  1 each  RAM strobes.
- ir_write  out  1  instruction register load enable.
- reg_dst  out  1  register-file destination: 0=rt, 1=rd.
- mem_to_reg  out  1  writeback mux: 1=MDR.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  ALU A mux: 0=PC, 1=regA.
- alu_src_b  out  2  ALU B mux: 00=regB, 01=4, 10=sign-ext, 11=sign-ext<<2.
- alu_op  out  3  ALU op: 000 add, 001 sub, 010 funct-decoded, 011 and, 100 or.
- pc_source  out  2  next-PC mux: 00=ALU, 01=ALUOut, 10=jump target.
- unsign  out  1  zero-extend immediate (andi, ori).
- state  out  4  current state code, for debug.
- illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode.
- instr_count  out  CNT_W  retired-instruction count.

## Operation
- Supported opcodes:
  - R-type 000000.
  - lw 100011, sw 101011.
  - beq 000100.
  - j 000010.
  - addi 001000, andi 001100, ori 001101.
- State codes:
  - RESET=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6.
  - R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, I_EXEC=11, I_WB=12.
- Outputs are Moore, decoded from state only. Any signal not listed for a state is 0.
- RESET: all outputs 0. Next state is FETCH.
- FETCH:
  - Signals: mem_read=1, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00, pc_write=1.
  - Next state: DECODE.
- DECODE:
  - Signals: alu_src_a=0, alu_src_b=11, alu_op=000 (precomputes the branch target).
  - Next state by opcode:
    - lw or sw → MEM_ADDR.
    - R-type → R_EXEC.
    - beq → BRANCH.
    - j → JUMP.
    - addi, andi, ori → I_EXEC.
    - anything else → FETCH, with illegal=1 during DECODE.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1. Next state MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH.
- MEM_WR: mem_write=1, iord=1. Next state FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=010. Next state R_WB.
- R_WB: reg_write=1, reg_dst=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01. Next state FETCH.
- JUMP: pc_write=1, pc_source=10. Next state FETCH.
- I_EXEC:
  - Signals: alu_src_a=1, alu_src_b=10.
  - alu_op: addi=000, andi=011, ori=100.
  - unsign=1 for andi and ori.
- I_WB: reg_write=1, reg_dst=0, with the same alu_op and unsign as I_EXEC. Next state FETCH.
- I_EXEC and I_WB decode opcode directly from the held IR; the IR is stable because ir_write=0 outside FETCH.
- instr_count:
  - Increments by 1 on each transition into FETCH from MEM_WB, MEM_WR, R_WB, BRANCH, JUMP or I_WB.
  - Illegal-opcode aborts (DECODE→FETCH) and RESET→FETCH do not count.
  - Wraps modulo 2^CNT_W.

## Timing
- Latency without stalls, counted in cycles from FETCH to the next FETCH:
  - lw 5.
  - sw, R-type, addi/andi/ori 4.
  - beq, j 3.
  - illegal opcode 2.
- Reset asserted mid-instruction: state goes to RESET immediately and asynchronously; outputs are 0 within the same cycle; instr_count=0. No partial write may complete after reset assertion.
- The first FETCH occurs on the first rising edge after reset deasserts.
- beq with zero=0: the PC keeps PC+4, which was written in FETCH.

## Configuration
- MCC_STALL_EN defined:
  - The mem_ready port exists.
  - FETCH, MEM_RD and MEM_WR hold their state and all their outputs while mem_ready=0.
  - pc_write in FETCH is gated by mem_ready, so the PC advances exactly once per fetch.
  - mem_ready is sampled only in those three states.
- MCC_STALL_EN undefined: no mem_ready port; each of those states lasts exactly one cycle.

## Structure
- Package mips_ctrl_pkg holds:
  - The state enum (4-bit codes above).
  - Opcode constants.
  - alu_op, alu_src_b and pc_source encodings.
- Sub-module mcc_opclass: combinational opcode → class decoder (MEM, RTYPE, BRANCH, JUMP, IMM, ILLEGAL) plus the immediate alu_op and unsign values. Instantiated once.
- The top level contains the state register, next-state logic, output decode and counter.

## Test plan
- Reset, then an R-type opcode:
  - States: RESET→FETCH→DECODE→R_EXEC→R_WB→FETCH.
  - reg_write=1 with reg_dst=1 in R_WB only.
  - instr_count=1.
- lw 100011: states 1,2,3,4,5,1; mem_read=1 with iord=1 in MEM_RD; mem_to_reg=1 in MEM_WB; count +1.
- beq, run twice:
  - With zero=1: pc_write_cond=1 and pc_source=01 in BRANCH.
  - With zero=0: the same strobes, and the PC-load check shows no load.
  - 3-cycle latency each time.
- Opcode 111111: illegal pulses for exactly 1 cycle in DECODE; next state FETCH; instr_count unchanged.
- Reset asserted asynchronously during MEM_WR: mem_write drops before the next edge; state=0; instr_count=0.
- MCC_STALL_EN, sw with mem_ready held 0 for 3 cycles in MEM_WR: the state holds for 4 cycles total; mem_write stays asserted throughout; exactly one increment.
